// File: rtl/mem_stage.sv
// MIPS memory-access stage: data-memory req/ack port, branch resolve,
// wait-state stall with timeout abort, and the MEM/WB pipeline register.
module mem_stage #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [0:2]  MIn,
  input  logic [0:1]  WBIn,
  input  logic [0:31] ALUResult,
  input  logic [0:31] AddResult,
  input  logic        ZeroIn,
  input  logic [0:31] RDIn2,
  input  logic [0:4]  MuxIn,
  output logic        mem_req,
  output logic        mem_we,
  output logic [0:31] mem_addr,
  output logic [0:31] mem_wdata,
  input  logic [0:31] mem_rdata,
  input  logic        mem_ack,
  output logic        PCSrc,
  output logic [0:31] BranchTarget,
  output logic        Stall,
  output logic        mem_err,
  output logic [0:1]  WBOut,
  output logic [0:31] ReadDataOut,
  output logic [0:31] ALUResultOut,
  output logic [0:4]  MuxOut
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [0:1]       r_wb;
  logic [0:31]      r_rdata;
  logic [0:31]      r_alu;
  logic [0:4]       r_mux;

  logic w_access;
  logic w_req;
  logic w_last;
  logic w_timeout;
  logic w_done;
  logic w_stall;

  // Request, abort and stall decode for the current access
  always_comb begin
    w_access  = MIn[1] | MIn[2];
    w_req     = w_access & ~rst;
    w_last    = (r_cnt == CNT_W'(TIMEOUT - 1));
    w_timeout = w_req & ~mem_ack & w_last;
    w_done    = w_req & (mem_ack | w_timeout);
    w_stall   = w_req & ~w_done;
  end

  assign mem_req      = w_req;
  assign mem_we       = MIn[2];
  assign mem_addr     = ALUResult;
  assign mem_wdata    = RDIn2;
  assign Stall        = w_stall;
  assign PCSrc        = MIn[0] & ZeroIn & ~rst;
  assign BranchTarget = AddResult;
  assign mem_err      = r_err;
  assign WBOut        = r_wb;
  assign ReadDataOut  = r_rdata;
  assign ALUResultOut = r_alu;
  assign MuxOut       = r_mux;

  // Access FSM: sit in WAIT while a request is unacknowledged
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_stall) r_state <= S_WAIT;
        S_WAIT:  if (w_done)  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Wait counter runs from the first request cycle; sticky abort flag
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if (w_stall)
        r_cnt <= r_cnt + 1'b1;
      else
        r_cnt <= '0;
      if (w_timeout)
        r_err <= 1'b1;
    end
  end

  // MEM/WB register; a stalled cycle injects a write-back bubble
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb    <= '0;
      r_rdata <= '0;
      r_alu   <= '0;
      r_mux   <= '0;
    end else begin
      if (w_stall) begin
        r_wb <= '0;
      end else begin
        r_wb  <= WBIn;
        r_alu <= ALUResult;
        r_mux <= MuxIn;
      end
      r_rdata <= (MIn[1] & mem_ack) ? mem_rdata : '0;
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a MEM/WB scoreboard queue.
// Expected write-back bundles are queued at issue and compared on retire.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [0:2]  MIn;
  logic [0:1]  WBIn;
  logic [0:31] ALUResult;
  logic [0:31] AddResult;
  logic        ZeroIn;
  logic [0:31] RDIn2;
  logic [0:4]  MuxIn;
  logic        mem_req;
  logic        mem_we;
  logic [0:31] mem_addr;
  logic [0:31] mem_wdata;
  logic [0:31] mem_rdata;
  logic        mem_ack;
  logic        PCSrc;
  logic [0:31] BranchTarget;
  logic        Stall;
  logic        mem_err;
  logic [0:1]  WBOut;
  logic [0:31] ReadDataOut;
  logic [0:31] ALUResultOut;
  logic [0:4]  MuxOut;

  typedef struct {
    logic [0:1]  wb;
    logic [0:31] rd;
    logic [0:31] alu;
    logic [0:4]  mux;
  } wb_t;

  wb_t sb[$];
  int  checks = 0;
  int  errors = 0;

  mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .MIn(MIn), .WBIn(WBIn),
    .ALUResult(ALUResult), .AddResult(AddResult),
    .ZeroIn(ZeroIn), .RDIn2(RDIn2), .MuxIn(MuxIn),
    .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .Stall(Stall), .mem_err(mem_err), .WBOut(WBOut),
    .ReadDataOut(ReadDataOut), .ALUResultOut(ALUResultOut),
    .MuxOut(MuxOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [0:1] wb, input logic [0:31] rd,
                      input logic [0:31] alu, input logic [0:4] mux);
    wb_t e;
    e.wb = wb; e.rd = rd; e.alu = alu; e.mux = mux;
    sb.push_back(e);
  endtask

  task automatic retire(input string tag);
    wb_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_wb"},  WBOut,        e.wb);
      chk({tag, "_rd"},  ReadDataOut,  e.rd);
      chk({tag, "_alu"}, ALUResultOut, e.alu);
      chk({tag, "_mux"}, MuxOut,       e.mux);
    end
  endtask

  task automatic drive(input logic [0:2] m, input logic [0:1] wb,
                       input logic [0:31] alu, input logic [0:4] mux,
                       input logic ack, input logic [0:31] rdata);
    MIn = m; WBIn = wb; ALUResult = alu; MuxIn = mux;
    mem_ack = ack; mem_rdata = rdata;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    drive(3'b010, 2'b11, 32'h55, 5'd1, 1'b0, 32'h0);
    AddResult = '0; ZeroIn = 1'b0; RDIn2 = '0;
    tick();
    tick();
    chk("rst_req",   mem_req, 1'b0);
    chk("rst_stall", Stall,   1'b0);
    chk("rst_wb",    WBOut,   2'b00);
    chk("rst_rd",    ReadDataOut, 32'h0);
    chk("rst_alu",   ALUResultOut, 32'h0);
    chk("rst_mux",   MuxOut,  5'd0);
    chk("rst_err",   mem_err, 1'b0);
    rst = 1'b0;

    // non-memory op
    drive(3'b000, 2'b10, 32'h7, 5'd3, 1'b0, 32'h0);
    push(2'b10, 32'h0, 32'h7, 5'd3);
    #1 chk("alu_stall", Stall, 1'b0);
    chk("alu_req", mem_req, 1'b0);
    tick();
    retire("alu");

    // zero-wait load
    drive(3'b010, 2'b11, 32'h40, 5'd5, 1'b1, 32'hCAFEF00D);
    push(2'b11, 32'hCAFEF00D, 32'h40, 5'd5);
    #1 chk("ld0_req", mem_req, 1'b1);
    chk("ld0_we",    mem_we,   1'b0);
    chk("ld0_addr",  mem_addr, 32'h40);
    chk("ld0_stall", Stall,    1'b0);
    tick();
    retire("ld0");

    // 3-wait load
    drive(3'b010, 2'b11, 32'h80, 5'd7, 1'b0, 32'h11223344);
    push(2'b11, 32'h11223344, 32'h80, 5'd7);
    for (int i = 0; i < 3; i++) begin
      #1 chk("ld3_stall", Stall, 1'b1);
      tick();
      chk("ld3_bubble", WBOut, 2'b00);
      chk("ld3_hold",   ALUResultOut, 32'h40);
    end
    mem_ack = 1'b1;
    #1 chk("ld3_done", Stall, 1'b0);
    tick();
    retire("ld3");

    // store that is never acknowledged
    drive(3'b001, 2'b00, 32'h200, 5'd0, 1'b0, 32'h0);
    RDIn2 = 32'h12345678;
    #1 chk("st_we",  mem_we,    1'b1);
    chk("st_wdata",  mem_wdata, 32'h12345678);
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("st_stalls", n, 15);
    chk("st_req16",  mem_req, 1'b1);
    chk("st_err_pre", mem_err, 1'b0);
    push(2'b00, 32'h0, 32'h200, 5'd0);
    tick();
    retire("st");
    chk("st_err", mem_err, 1'b1);

    // branch resolve; error stays sticky
    drive(3'b100, 2'b00, 32'h9, 5'd2, 1'b0, 32'h0);
    AddResult = 32'h100; ZeroIn = 1'b1;
    #1 chk("br_take", PCSrc, 1'b1);
    chk("br_tgt",   BranchTarget, 32'h100);
    chk("br_req",   mem_req, 1'b0);
    ZeroIn = 1'b0;
    #1 chk("br_ntake", PCSrc, 1'b0);
    push(2'b00, 32'h0, 32'h9, 5'd2);
    tick();
    retire("br");
    chk("err_sticky", mem_err, 1'b1);

    // reset while a load is waiting
    drive(3'b010, 2'b11, 32'h300, 5'd9, 1'b0, 32'h0);
    #1 chk("rw_stall1", Stall, 1'b1);
    tick();
    chk("rw_stall2", Stall, 1'b1);
    tick();
    rst = 1'b1;
    #1 chk("rw_req", mem_req, 1'b0);
    chk("rw_stall", Stall, 1'b0);
    tick();
    chk("rw_wb",  WBOut, 2'b00);
    chk("rw_rd",  ReadDataOut, 32'h0);
    chk("rw_alu", ALUResultOut, 32'h0);
    chk("rw_mux", MuxOut, 5'd0);
    chk("rw_err", mem_err, 1'b0);
    rst = 1'b0;
    drive(3'b010, 2'b01, 32'h44, 5'd4, 1'b1, 32'hDEADBEEF);
    push(2'b01, 32'hDEADBEEF, 32'h44, 5'd4);
    #1 chk("rw_ld_stall", Stall, 1'b0);
    tick();
    retire("rw_ld");

    // fresh timeout after reset must again take the full window
    drive(3'b010, 2'b10, 32'h48, 5'd6, 1'b0, 32'h0);
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 40) begin
      tick();
      n++;
    end
    chk("to2_stalls", n, 15);
    push(2'b10, 32'h0, 32'h48, 5'd6);
    tick();
    retire("to2");
    chk("to2_err", mem_err, 1'b1);
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage of the 5-stage MIPS pipeline. Sits directly downstream of the EX/MEM pipeline register and consumes its outputs (M/WB control, ALU result, branch target, zero flag, store data, destination register).
- Drives a req/ack data-memory port, resolves branches, and stalls the pipeline while a memory access is outstanding.
- Contains the MEM/WB pipeline register feeding write-back.

Parameters:
- TIMEOUT, 16, consecutive unacknowledged request cycles before the access is aborted (minimum 2).
- CNT_W, 5, width of the wait counter; must hold TIMEOUT-1.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- MIn  in  [0:2]  from EX/MEM: [0]=Branch, [1]=MemRead, [2]=MemWrite.
- WBIn  in  [0:1]  from EX/MEM: [0]=RegWrite, [1]=MemtoReg.
- ALUResult  in  [0:31]  memory address / ALU value.
- AddResult  in  [0:31]  branch target.
- ZeroIn  in  1  ALU zero flag.
- RDIn2  in  [0:31]  store data.
- MuxIn  in  [0:4]  destination register number.
- mem_req  out  1  data-memory request.
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  [0:31]  memory address.
- mem_wdata  out  [0:31]  write data.
- mem_rdata  in  [0:31]  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete (same-cycle ack allowed).
- PCSrc  out  1  take branch.
- BranchTarget  out  [0:31]  branch target to PC mux.
- Stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle.
- mem_err  out  1  sticky timeout flag.
- WBOut  out  [0:1]  MEM/WB control.
- ReadDataOut  out  [0:31]  MEM/WB load data.
- ALUResultOut  out  [0:31]  MEM/WB ALU value.
- MuxOut  out  [0:4]  MEM/WB destination register.

Behaviour:
- Clock/reset: one clock, clk. Reset is synchronous and active-high, on rst.
- Reset values: WBOut, ReadDataOut, ALUResultOut, MuxOut, mem_err, the wait counter and the FSM (IDLE) all go to 0. While rst=1, mem_req, Stall and PCSrc are forced to 0.
- Combinational outputs:
  - access = MIn[1] | MIn[2].
  - mem_req = access & ~rst.
  - mem_we = MIn[2].
  - mem_addr = ALUResult.
  - mem_wdata = RDIn2.
  - Upstream holds these inputs stable while Stall=1.
- Timeout and stall:
  - timeout = mem_req & ~mem_ack & (cnt == TIMEOUT-1).
  - done = mem_req & (mem_ack | timeout).
  - Stall = mem_req & ~done.
- Branch: PCSrc = MIn[0] & ZeroIn & ~rst; BranchTarget = AddResult. Branch and memory bits are never both set by the decoder, so no interaction is required.
- FSM:
  - IDLE -> WAIT when Stall=1.
  - WAIT -> IDLE when done=1.
  - IDLE/WAIT -> IDLE on rst.
- Wait counter (cnt): increments each cycle Stall=1; clears when done or when there is no request. Counting starts in the first request cycle, so a request that is never acked completes after exactly TIMEOUT cycles.
- Timeout: sets mem_err=1, which stays set until rst. An aborted read returns 0. An aborted write is dropped (the memory must ignore it once req falls).
- MEM/WB register, each rising edge with rst=0:
  - If Stall=1: WBOut <= 0 (bubble so write-back never repeats). Other fields hold.
  - Else: WBOut <= WBIn, ALUResultOut <= ALUResult, MuxOut <= MuxIn.
  - ReadDataOut <= (MIn[1] & mem_ack) ? mem_rdata : 0.
- Latency: non-memory op or zero-wait access takes 1 cycle (MEM/WB updated on the next edge). An access acked after N wait cycles asserts Stall for N cycles, then updates MEM/WB.
- Back-to-back accesses: there is no idle gap. The completing cycle drops Stall, the upstream advances, and the next access requests on the following cycle.
- mem_ack with mem_req=0 is ignored.
- Reset during WAIT: request drops in the same cycle, FSM returns to IDLE, cnt=0, no MEM/WB update.

Test Plan:
- Reset and non-memory op: rst=1 for 2 cycles, then WBIn=2'b10, ALUResult=0x00000007, MuxIn=5'd3, MIn=0 -> after 1 edge WBOut=2'b10, ALUResultOut=7, MuxOut=3, ReadDataOut=0, Stall never asserted.
- Zero-wait load: MIn=3'b010, ALUResult=0x40, mem_ack=1 same cycle, mem_rdata=0xCAFEF00D -> mem_req=1, mem_we=0, mem_addr=0x40, Stall=0, next edge ReadDataOut=0xCAFEF00D, WBOut=WBIn.
- 3-wait load: ack on the 4th request cycle -> Stall=1 for exactly 3 cycles, WBOut=0 after each stalled edge, then ReadDataOut=mem_rdata and WBOut=WBIn.
- Store timeout: MIn=3'b001, RDIn2=0x12345678, mem_ack held 0 -> mem_we=1, mem_wdata=0x12345678, Stall=1 for TIMEOUT-1=15 cycles, 16th cycle Stall=0, mem_err=1 and stays 1.
- Branch: MIn=3'b100, ZeroIn=1, AddResult=0x100 -> PCSrc=1, BranchTarget=0x100; with ZeroIn=0, PCSrc=0.
- Reset mid-WAIT: load pending 2 cycles, assert rst -> mem_req=0 and Stall=0 that cycle, all MEM/WB outputs 0 after the edge, mem_err=0, next load with immediate ack completes in 1 cycle.
